cordic_arbiter: RTL and testbench

Round-robin scheduler sharing one `sin_cos` CORDIC core between `N_REQ` requesters. It accepts phase requests over valid/ready handshakes and issues at most one phase per cycle to the core. Each issued requester index is tracked in an in-flight tag FIFO, and each result is routed back to the requester that issued it. The block sits directly in front of the `sin_cos` instance, and its `cordic_*` ports connect straight to the core's ports.

---
 rtl/cordic_pkg.sv | 27 ++
 rtl/cordic_tag_fifo.sv | 72 +++++++
 rtl/cordic_arbiter.sv | 154 +++++++++++++++
 tb/tb_cordic_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, fixed-point formats and clog2 for the CORDIC arbiter
package cordic_pkg;

    // Phase is 1.2.13; sin and cos are 1.1.14.
    localparam int PHASE_W    = 16;
    localparam int PHASE_FRAC = 13;
    localparam int SIN_W      = 16;
    localparam int SIN_FRAC   = 14;
    localparam int COS_W      = 16;
    localparam int COS_FRAC   = 14;

    localparam logic [15:0] P_PI   = 16'h6488;
    localparam logic [15:0] N_PI   = 16'h9B78;
    localparam logic [15:0] TWO_PI = 16'hC910;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// rtl/cordic_tag_fifo.sv - in-flight requester tag FIFO with occupancy count
module cordic_tag_fifo
    import cordic_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [TAG_W-1:0]         tag_i,
    input  logic                     pop_i,
    output logic [TAG_W-1:0]         head_o,
    output logic [clog2(DEPTH):0]    count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= tag_i;
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin front end sharing one sin_cos core; CORDIC_PHASE_WRAP_EN wraps out-of-range phases
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int Width = 16,
    parameter int N_REQ = 4,
    parameter int DEPTH = 32
) (
    input  logic                      aclk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*Width-1:0]    req_phase,
    output logic                      cordic_phase_valid,
    output logic [Width-1:0]          cordic_phase,
    input  logic                      cordic_sin_cos_valid,
    input  logic [Width-1:0]          cordic_sin,
    input  logic [Width-1:0]          cordic_cos,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [Width-1:0]          rsp_sin,
    output logic [Width-1:0]          rsp_cos,
    output logic [clog2(N_REQ)-1:0]   rsp_id,
    output logic [clog2(DEPTH):0]     inflight,
    output logic                      err_underflow
);

    localparam int IDW = clog2(N_REQ);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             issue;
    logic [Width-1:0] sel_phase;
    logic [Width-1:0] issue_phase;

    logic             cpv_q, cpv_d;
    logic [Width-1:0] cphase_q, cphase_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [Width-1:0] rsp_sin_q, rsp_sin_d;
    logic [Width-1:0] rsp_cos_q, rsp_cos_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             err_q, err_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [IDW-1:0]   head_tag;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = IDW'((int'(ptr_q) + k) % N_REQ);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Full is judged on the registered count only; a same-cycle pop earns no credit.
    assign issue     = gnt_found && !fifo_full && !rst;
    assign req_ready = issue ? (N_REQ'(1) << gnt_idx) : '0;
    assign sel_phase = req_phase[gnt_idx*Width +: Width];
    assign pop       = cordic_sin_cos_valid && !fifo_empty;

`ifdef CORDIC_PHASE_WRAP_EN
    logic [Width:0] wrap_ext;

    always_comb begin
        wrap_ext = {sel_phase[Width-1], sel_phase};
        if ($signed(sel_phase) > $signed(Width'(P_PI))) begin
            wrap_ext = wrap_ext - {1'b0, Width'(TWO_PI)};
        end else if ($signed(sel_phase) < $signed(Width'(N_PI))) begin
            wrap_ext = wrap_ext + {1'b0, Width'(TWO_PI)};
        end
        issue_phase = Width'(wrap_ext);
    end
`else
    assign issue_phase = sel_phase;
`endif

    always_comb begin
        ptr_d       = ptr_q;
        cpv_d       = issue;
        cphase_d    = cphase_q;
        rsp_valid_d = '0;
        rsp_sin_d   = rsp_sin_q;
        rsp_cos_d   = rsp_cos_q;
        rsp_id_d    = rsp_id_q;
        err_d       = err_q;
        if (issue) begin
            cphase_d = issue_phase;
            ptr_d    = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        if (pop) begin
            rsp_valid_d = N_REQ'(1) << head_tag;
            rsp_sin_d   = cordic_sin;
            rsp_cos_d   = cordic_cos;
            rsp_id_d    = head_tag;
        end
        if (cordic_sin_cos_valid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            ptr_q       <= '0;
            cpv_q       <= 1'b0;
            cphase_q    <= '0;
            rsp_valid_q <= '0;
            rsp_sin_q   <= '0;
            rsp_cos_q   <= '0;
            rsp_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cpv_q       <= cpv_d;
            cphase_q    <= cphase_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sin_q   <= rsp_sin_d;
            rsp_cos_q   <= rsp_cos_d;
            rsp_id_q    <= rsp_id_d;
            err_q       <= err_d;
        end
    end

    cordic_tag_fifo #(
        .TAG_W (IDW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i   (aclk),
        .rst_i   (rst),
        .push_i  (issue),
        .tag_i   (gnt_idx),
        .pop_i   (pop),
        .head_o  (head_tag),
        .count_o (inflight),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cordic_phase_valid = cpv_q;
    assign cordic_phase       = cphase_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_sin            = rsp_sin_q;
    assign rsp_cos            = rsp_cos_q;
    assign rsp_id             = rsp_id_q;
    assign err_underflow      = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - self-checking bench for cordic_arbiter with a stub fixed-latency core
`timescale 1ns/1ps
module tb_cordic_arbiter;

    localparam int W = 16;
    localparam int N = 4;
    localparam int D = 32;

    logic           aclk = 1'b0;
    logic           rst  = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_phase = '0;
    logic [N-1:0]   req_ready;
    logic           cpv;
    logic [W-1:0]   cphase;
    logic           scv;
    logic [W-1:0]   csin;
    logic [W-1:0]   ccos;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_sin;
    logic [W-1:0]   rsp_cos;
    logic [1:0]     rsp_id;
    logic [5:0]     inflight;
    logic           err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    cordic_arbiter #(.Width(W), .N_REQ(N), .DEPTH(D)) dut (
        .aclk                 (aclk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_phase            (req_phase),
        .cordic_phase_valid   (cpv),
        .cordic_phase         (cphase),
        .cordic_sin_cos_valid (scv),
        .cordic_sin           (csin),
        .cordic_cos           (ccos),
        .rsp_valid            (rsp_valid),
        .rsp_sin              (rsp_sin),
        .rsp_cos              (rsp_cos),
        .rsp_id               (rsp_id),
        .inflight             (inflight),
        .err_underflow        (err)
    );

    // Stub core: fixed-latency delay line, sin = phase, cos = phase + 0x4000; reset with the arbiter.
    int           lat    = 20;
    logic         inject = 1'b0;
    logic         pv [64];
    logic [W-1:0] pp [64];

    always @(posedge aclk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                pv[i] <= 1'b0;
                pp[i] <= '0;
            end
        end else begin
            pv[0] <= cpv;
            pp[0] <= cphase;
            for (int i = 1; i < 64; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
            end
        end
    end

    assign scv  = pv[lat-1] | inject;
    assign csin = pp[lat-1];
    assign ccos = pp[lat-1] + 16'h4000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] wrap(input logic [15:0] p);
`ifdef CORDIC_PHASE_WRAP_EN
        int v;
        v = int'($signed(p));
        if (v > 25736) v = v - 51472;
        else if (v < -25736) v = v + 51472;
        return 16'(v);
`else
        return p;
`endif
    endfunction

    // Transaction-level model: pointer, tag queue, sticky error, and the registered outputs it implies.
    int           m_ptr = 0;
    int           m_q[$];
    logic         e_cpv = 1'b0;
    logic [W-1:0] e_cph = '0;
    logic [N-1:0] e_rv  = '0;
    logic [W-1:0] e_sin = '0;
    logic [W-1:0] e_cos = '0;
    logic [1:0]   e_id  = '0;
    logic         e_err = 1'b0;

    int gnt_cyc[$];
    int gnt_idx[$];
    int cpv_cyc[$];
    int rsp_cyc[$];
    int rsp_idx[$];
    int peak = 0;

    always @(negedge aclk) begin
        int g;
        int h;
        int idx;
        logic [N-1:0] exp_rdy;
        g = -1;
        if (!rst && m_q.size() < D) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", req_ready, exp_rdy);
        chk("cordic_phase_valid", cpv, e_cpv);
        chk("cordic_phase", cphase, e_cph);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_sin", rsp_sin, e_sin);
        chk("rsp_cos", rsp_cos, e_cos);
        chk("rsp_id", rsp_id, e_id);
        chk("inflight", inflight, m_q.size());
        chk("err_underflow", err, e_err);

        for (int k = 0; k < N; k++) begin
            if (req_ready[k]) begin
                gnt_cyc.push_back(cyc);
                gnt_idx.push_back(k);
            end
            if (rsp_valid[k]) begin
                rsp_cyc.push_back(cyc);
                rsp_idx.push_back(k);
            end
        end
        if (cpv) cpv_cyc.push_back(cyc);
        if (rst) peak = 0;
        else if (int'(inflight) > peak) peak = int'(inflight);

        if (rst) begin
            m_q.delete();
            m_ptr = 0;
            e_cpv = 1'b0; e_cph = '0; e_rv = '0; e_sin = '0; e_cos = '0; e_id = '0; e_err = 1'b0;
        end else begin
            e_cpv = (g >= 0);
            e_rv  = '0;
            if (scv) begin
                if (m_q.size() > 0) begin
                    h = m_q.pop_front();
                    e_rv  = N'(1 << h);
                    e_sin = csin;
                    e_cos = ccos;
                    e_id  = 2'(h);
                end else begin
                    e_err = 1'b1;
                end
            end
            if (g >= 0) begin
                e_cph = wrap(req_phase[g*W +: W]);
                m_q.push_back(g);
                m_ptr = (g + 1) % N;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int maxc, input string nm);
        int n;
        n = 0;
        while (rsp_idx.size() < target && n < maxc) begin
            tick(1);
            n++;
        end
        chk(nm, rsp_idx.size(), target);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((inflight != 0 || scv) && n < 200) begin
            tick(1);
            n++;
        end
        chk(nm, inflight, 0);
    endtask

    initial begin
        int gs, rs, cs, cnt, r;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("reset inflight", inflight, 0);
        chk("reset err", err, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset cpv", cpv, 0);

        // Single requester, phase 0, core latency 20.
        lat = 20;
        gs = gnt_cyc.size(); rs = rsp_idx.size(); cs = cpv_cyc.size();
        req_phase[0 +: W] = 16'h0000;
        req_valid = 4'b0001;
        tick(1);
        req_valid = '0;
        wait_rsp(rs + 1, 60, "t1 response arrives");
        if (rsp_idx.size() > rs && cpv_cyc.size() > cs) begin
            chk("t1 phase_valid latency", cpv_cyc[cs] - gnt_cyc[gs], 1);
            chk("t1 rsp latency", rsp_cyc[rs] - gnt_cyc[gs], 22);
            chk("t1 rsp id", rsp_idx[rs], 0);
        end
        chk("t1 rsp_sin", rsp_sin, 16'h0000);
        chk("t1 rsp_cos", rsp_cos, 16'h4000);

        // All four requesters for eight cycles.
        do_reset();
        gs = gnt_cyc.size(); rs = rsp_idx.size();
        for (int i = 0; i < N; i++) req_phase[i*W +: W] = 16'(16'h0110 * (i + 1));
        req_valid = 4'hF;
        tick(8);
        req_valid = '0;
        wait_rsp(rs + 8, 60, "t2 responses arrive");
        chk("t2 grant count", gnt_cyc.size() - gs, 8);
        for (int k = 0; k < 8; k++) begin
            if (gnt_idx.size() > gs + k) chk("t2 grant order", gnt_idx[gs + k], k % 4);
            if (rsp_idx.size() > rs + k) chk("t2 rsp_id order", rsp_idx[rs + k], k % 4);
        end

        // 40-cycle core with continuous requests fills the tag FIFO.
        do_reset();
        lat = 40;
        gs = gnt_cyc.size(); rs = rsp_idx.size();
        req_valid = 4'hF;
        tick(60);
        chk("t3 peak inflight", peak, 32);
        req_valid = '0;
        wait_idle("t3 drain");
        if (rsp_cyc.size() > rs && gnt_cyc.size() > gs + 32) begin
            r = rsp_cyc[rs];
            cnt = 0;
            for (int k = gs; k < gnt_cyc.size(); k++) if (gnt_cyc[k] < r) cnt++;
            chk("t3 grants before first result", cnt, 32);
            chk("t3 first grant after stall", gnt_cyc[gs + 32], r);
        end else begin
            chk("t3 enough traffic", gnt_cyc.size() - gs, 33);
        end

        // Result with nothing in flight.
        do_reset();
        lat = 20;
        rs = rsp_idx.size();
        inject = 1'b1;
        tick(1);
        inject = 1'b0;
        chk("t4 err set", err, 1);
        chk("t4 no rsp_valid", rsp_valid, 0);
        tick(5);
        chk("t4 err sticky", err, 1);
        chk("t4 no responses", rsp_idx.size(), rs);
        do_reset();
        chk("t4 err cleared", err, 0);

        // Reset with ten requests in flight.
        req_phase[1*W +: W] = 16'h1234;
        req_valid = 4'b0010;
        tick(10);
        req_valid = '0;
        tick(2);
        chk("t5 inflight before reset", inflight, 10);
        rst = 1'b1;
        tick(1);
        chk("t5 req_ready", req_ready, 0);
        chk("t5 cpv", cpv, 0);
        chk("t5 cphase", cphase, 0);
        chk("t5 rsp_valid", rsp_valid, 0);
        chk("t5 rsp_sin", rsp_sin, 0);
        chk("t5 rsp_cos", rsp_cos, 0);
        chk("t5 rsp_id", rsp_id, 0);
        chk("t5 inflight", inflight, 0);
        chk("t5 err", err, 0);
        tick(1);
        rst = 1'b0;

        // Out-of-range phases.
        req_phase[0 +: W] = 16'h7000;
        req_valid = 4'b0001;
        tick(1);
        req_valid = '0;
`ifdef CORDIC_PHASE_WRAP_EN
        chk("t6 wrap high", cphase, 16'hA6F0);
`else
        chk("t6 pass high", cphase, 16'h7000);
`endif
        req_phase[0 +: W] = 16'h9000;
        req_valid = 4'b0001;
        tick(1);
        req_valid = '0;
`ifdef CORDIC_PHASE_WRAP_EN
        chk("t6 wrap low", cphase, 16'h5910);
`else
        chk("t6 pass low", cphase, 16'h9000);
`endif
        wait_idle("t6 drain");

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
